// File: rtl/usb_uart_bridge_if.sv
`default_nettype none
// ============================================================================
// usb_uart_bridge_if : USB endpoint handshake bundle (IN and OUT directions).
// Rev 1.0
// ============================================================================
interface usb_uart_bridge_if;
  logic        txact;
  logic        txpop;
  logic [3:0]  endpt;
  logic        txval;
  logic        txcork;
  logic [7:0]  txdat;
  logic [11:0] txdat_len;
  logic        rxact;
  logic        rxval;
  logic        rxrdy;
  logic [7:0]  rxdat;

  modport master (
    output txact, txpop, endpt, rxact, rxval, rxdat,
    input  txval, txcork, txdat, txdat_len, rxrdy
  );

  modport slave (
    input  txact, txpop, endpt, rxact, rxval, rxdat,
    output txval, txcork, txdat, txdat_len, rxrdy
  );
endinterface
`default_nettype wire

// File: rtl/usb_uart_bridge.sv
`default_nettype none
// ============================================================================
// usb_uart_bridge : USB endpoint <-> 8N1 UART bridge, OUT via tfifo, IN via rfifo.
// Macro USB_UART_LOOPBACK_EN feeds uart_tx back into the receiver.  Rev 1.0
// ============================================================================
module usb_uart_bridge #(
  parameter logic [3:0] EP      = 4'd2,
  parameter int         CLK_DIV = 104,
  parameter int         DEPTH   = 64,
  parameter int         MAX_PKT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  usb_uart_bridge_if.slave usb,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic             frm_err,
  output logic             ovf
);
  localparam int              CW       = $clog2(CLK_DIV + 1);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              PW       = AW + 1;
  localparam logic [CW-1:0]   BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [PW-1:0]   FULL_CNT = PW'(DEPTH);
  localparam logic [11:0]     MAX_LEN  = 12'(MAX_PKT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic [7:0]    tf_mem_q [DEPTH];
  logic [7:0]    rf_mem_q [DEPTH];
  logic [PW-1:0] tf_wr_q, tf_wr_d, tf_rd_q, tf_rd_d;
  logic [PW-1:0] rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
  logic [PW-1:0] tf_cnt, rf_cnt;
  logic          tf_full, tf_empty, rf_full, rf_empty;
  logic          tf_push, tf_pop, rf_push, rf_pop;
  logic          ep_hit;

  logic [11:0]   txdat_len_q, txdat_len_d;
  logic          txcork_q, txcork_d, txact_q, txact_d, frz_q, frz_d;

  state_e        tx_state_q, rx_state_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic [2:0]    tx_bit_q, rx_bit_q;
  logic [7:0]    tx_sh_q, rx_sh_q;
  logic          uart_tx_q, frm_err_q, ovf_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_in;
  logic          tx_bit_end, rx_bit_end, rx_stop_smp;

  assign tf_cnt   = tf_wr_q - tf_rd_q;
  assign rf_cnt   = rf_wr_q - rf_rd_q;
  assign tf_full  = (tf_cnt == FULL_CNT);
  assign rf_full  = (rf_cnt == FULL_CNT);
  assign tf_empty = (tf_wr_q == tf_rd_q);
  assign rf_empty = (rf_wr_q == rf_rd_q);

  assign ep_hit        = (usb.endpt == EP);
  assign usb.rxrdy     = rst_n && usb.rxact && ep_hit && !tf_full;
  assign tf_push       = usb.rxval && usb.rxrdy;
  assign rf_pop        = usb.txact && usb.txpop && ep_hit && !rf_empty;
  assign usb.txval     = !rf_empty;
  assign usb.txdat     = rf_empty ? 8'h00 : rf_mem_q[rf_rd_q[AW-1:0]];
  assign usb.txdat_len = txdat_len_q;
  assign usb.txcork    = txcork_q;
  assign uart_tx       = uart_tx_q;
  assign frm_err       = frm_err_q;
  assign ovf           = ovf_q;

`ifdef USB_UART_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_in          = uart_tx_q;
`else
  assign rx_in = uart_rx;
`endif

  // Length/cork snapshot freezes on an IN rising at our endpoint, held until txact drops.
  always_comb begin
    tf_wr_d     = tf_wr_q + {{(PW-1){1'b0}}, tf_push};
    tf_rd_d     = tf_rd_q + {{(PW-1){1'b0}}, tf_pop};
    rf_wr_d     = rf_wr_q + {{(PW-1){1'b0}}, rf_push};
    rf_rd_d     = rf_rd_q + {{(PW-1){1'b0}}, rf_pop};
    txact_d     = usb.txact;
    frz_d       = usb.txact && (frz_q || (!txact_q && ep_hit));
    txdat_len_d = txdat_len_q;
    txcork_d    = txcork_q;
    if (!frz_d) begin
      txdat_len_d = (12'(rf_cnt) > MAX_LEN) ? MAX_LEN : 12'(rf_cnt);
      txcork_d    = (rf_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tf_wr_q     <= '0;
      tf_rd_q     <= '0;
      rf_wr_q     <= '0;
      rf_rd_q     <= '0;
      txdat_len_q <= '0;
      txcork_q    <= 1'b1;
      txact_q     <= 1'b0;
      frz_q       <= 1'b0;
    end else begin
      tf_wr_q     <= tf_wr_d;
      tf_rd_q     <= tf_rd_d;
      rf_wr_q     <= rf_wr_d;
      rf_rd_q     <= rf_rd_d;
      txdat_len_q <= txdat_len_d;
      txcork_q    <= txcork_d;
      txact_q     <= txact_d;
      frz_q       <= frz_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tf_push) tf_mem_q[tf_wr_q[AW-1:0]] <= usb.rxdat;
    if (rf_push) rf_mem_q[rf_wr_q[AW-1:0]] <= rx_sh_q;
  end

  // A byte is loaded from IDLE or straight out of the stop bit, so frames run back-to-back.
  assign tx_bit_end = (tx_cnt_q == BIT_END);
  assign tf_pop     = !tf_empty && ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_bit_end));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      uart_tx_q  <= 1'b1;
    end else if (tf_pop) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= tf_mem_q[tf_rd_q[AW-1:0]];
      uart_tx_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: tx_cnt_q <= '0;
        S_START: begin
          if (tx_bit_end) begin
            tx_state_q <= S_DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            uart_tx_q  <= tx_sh_q[0];
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              uart_tx_q  <= 1'b1;
            end else begin
              tx_bit_q  <= tx_bit_q + 1'b1;
              tx_sh_q   <= {1'b0, tx_sh_q[7:1]};
              uart_tx_q <= tx_sh_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_STOP: begin
          if (tx_bit_end) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // A full rfifo still takes a byte when the host pops in the same cycle.
  assign rx_bit_end  = (rx_cnt_q == BIT_END);
  assign rx_stop_smp = (rx_state_q == S_STOP) && rx_bit_end;
  assign rf_push     = rx_stop_smp && rx_s2_q && (!rf_full || rf_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      frm_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      frm_err_q <= rx_stop_smp && !rx_s2_q;
      ovf_q     <= rx_stop_smp && rx_s2_q && rf_full && !rf_pop;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_usb_uart_bridge.sv
`default_nettype none
// tb_usb_uart_bridge : randomized bench with a bench-side UART line decoder
// and queue models of both FIFOs (CLK_DIV=16, DEPTH=8).
module tb_usb_uart_bridge;
  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 8;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, frm_err, ovf;

  usb_uart_bridge_if bus();

  usb_uart_bridge #(
    .EP(4'd2), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .MAX_PKT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .usb(bus),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .frm_err(frm_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ovf_cnt = 0;
  int          frm_cnt = 0;
  logic [7:0]  mon_byte[$];
  logic        mon_ok[$];
  int          mon_start[$];
  logic [7:0]  rq[$];
  logic [7:0]  tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovf === 1'b1) ovf_cnt++;
    if (frm_err === 1'b1) frm_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_uart_tx"}, 32'(uart_tx), 1);
    check_val({tag, "_txval"}, 32'(bus.txval), 0);
    check_val({tag, "_txcork"}, 32'(bus.txcork), 1);
    check_val({tag, "_txdat"}, 32'(bus.txdat), 0);
    check_val({tag, "_txdat_len"}, 32'(bus.txdat_len), 0);
    check_val({tag, "_rxrdy"}, 32'(bus.rxrdy), 0);
    check_val({tag, "_frm_err"}, 32'(frm_err), 0);
    check_val({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  // Serial frame on uart_rx, one bit per CLK_DIV cycles, starting at a negedge.
  task automatic send_serial(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_mon(input int n, input int limit);
    int w;
    w = 0;
    while (mon_byte.size() < n && w < limit) begin
      @(negedge clk);
      w++;
    end
    check_val("mon_frames", 32'(mon_byte.size()), 32'(n));
  endtask

  // Line decoder: samples each bit centre; frames overlapping reset are discarded.
  initial begin : uart_mon
    logic [7:0] b;
    logic       st_ok, sp_ok, aborted;
    int         t0, k;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc; b = '0; st_ok = 1'b0; sp_ok = 1'b0; aborted = 1'b0;
        for (int t = 1; t <= 9 * CLK_DIV + CLK_DIV / 2; t++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          if (t % CLK_DIV == CLK_DIV / 2) begin
            k = t / CLK_DIV;
            if (k == 0) st_ok = (uart_tx === 1'b0);
            else if (k <= 8) b[k-1] = uart_tx;
            else sp_ok = (uart_tx === 1'b1);
          end
        end
        if (!aborted) begin
          mon_byte.push_back(b);
          mon_ok.push_back(st_ok && sp_ok);
          mon_start.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] b;
    int         base, o0, f0, exp_ovf, level, w;
    logic       p;
    bus.txact = 1'b0; bus.txpop = 1'b0; bus.endpt = 4'd0;
    bus.rxact = 1'b0; bus.rxval = 1'b0; bus.rxdat = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef USB_UART_LOOPBACK_EN
    uart_rx = 1'b0;
    bus.rxact = 1'b1; bus.endpt = 4'd2;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      check_val("lb_rxrdy", 32'(bus.rxrdy), 1);
      bus.rxdat = 8'(i); bus.rxval = 1'b1;
      rq.push_back(8'(i));
      @(negedge clk);
    end
    bus.rxval = 1'b0; bus.rxact = 1'b0;
    repeat (4 * FRAME + 100) @(negedge clk);
    check_val("lb_len", 32'(bus.txdat_len), 4);
    check_val("lb_cork", 32'(bus.txcork), 0);
    bus.txact = 1'b1;
    while (rq.size() > 0) begin
      check_val("lb_txdat", 32'(bus.txdat), 32'(rq[0]));
      bus.txpop = 1'b1;
      @(negedge clk);
      void'(rq.pop_front());
    end
    bus.txact = 1'b0; bus.txpop = 1'b0;
    repeat (2) @(negedge clk);
    check_val("lb_cork_empty", 32'(bus.txcork), 1);
`else
    // Two OUT bytes become back-to-back frames on uart_tx.
    base = mon_byte.size();
    bus.rxact = 1'b1; bus.endpt = 4'd2;
    @(negedge clk);
    tq = '{8'h55, 8'hA3};
    foreach (tq[i]) begin
      check_val("out_rxrdy", 32'(bus.rxrdy), 1);
      bus.rxdat = tq[i]; bus.rxval = 1'b1;
      @(negedge clk);
    end
    bus.rxval = 1'b0; bus.rxact = 1'b0;
    wait_mon(base + 2, 3 * FRAME);
    for (int i = 0; i < 2; i++) begin
      check_val("tx_byte", 32'(mon_byte[base+i]), 32'(tq[i]));
      check_val("tx_framing", 32'(mon_ok[base+i]), 1);
    end
    check_val("tx_gap", 32'(mon_start[base+1] - mon_start[base]), 32'(FRAME));

    // Single serial byte into the IN path, then one pop.
    send_serial(8'h96, 1'b1);
    rq.push_back(8'h96);
    check_val("in_cork", 32'(bus.txcork), 0);
    check_val("in_txdat", 32'(bus.txdat), 32'(rq[0]));
    check_val("in_len", 32'(bus.txdat_len), 32'(rq.size()));
    bus.txact = 1'b1; bus.endpt = 4'd2; bus.txpop = 1'b1;
    @(negedge clk);
    void'(rq.pop_front());
    bus.txact = 1'b0; bus.txpop = 1'b0;
    repeat (2) @(negedge clk);
    check_val("pop_cork", 32'(bus.txcork), 1);
    check_val("pop_txval", 32'(bus.txval), 0);

    // Nine random bytes into an 8-deep rfifo, then a framing error.
    o0 = ovf_cnt; exp_ovf = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      send_serial(b, 1'b1);
      if (rq.size() < DEPTH) rq.push_back(b);
      else exp_ovf++;
    end
    repeat (4) @(negedge clk);
    check_val("ovf_pulses", 32'(ovf_cnt - o0), 32'(exp_ovf));
    check_val("full_len", 32'(bus.txdat_len), 32'(rq.size()));
    check_val("full_cork", 32'(bus.txcork), 0);
    f0 = frm_cnt;
    send_serial(8'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    check_val("frm_err_pulses", 32'(frm_cnt - f0), 1);
    check_val("frm_len", 32'(bus.txdat_len), 32'(rq.size()));

    // Pops addressed to another endpoint are ignored.
    bus.txact = 1'b1; bus.endpt = 4'd3; bus.txpop = 1'b1;
    repeat (4) @(negedge clk);
    check_val("ep3_txdat", 32'(bus.txdat), 32'(rq[0]));
    bus.txact = 1'b0; bus.txpop = 1'b0; bus.endpt = 4'd2;
    repeat (2) @(negedge clk);
    check_val("ep3_len", 32'(bus.txdat_len), 32'(rq.size()));

    // Drain with random pop gaps; length stays frozen while txact is high.
    bus.txact = 1'b1;
    @(negedge clk);
    w = 0;
    while (rq.size() > 0 && w < 100) begin
      check_val("drain_txdat", 32'(bus.txdat), 32'(rq[0]));
      p = 1'($urandom_range(0, 1));
      bus.txpop = p;
      @(negedge clk);
      if (p) void'(rq.pop_front());
      w++;
    end
    bus.txpop = 1'b0;
    check_val("len_frozen", 32'(bus.txdat_len), 32'(DEPTH));
    bus.txact = 1'b0;
    repeat (2) @(negedge clk);
    check_val("drain_cork", 32'(bus.txcork), 1);
    check_val("drain_len", 32'(bus.txdat_len), 0);

    // Pops on an empty rfifo leave the pointers intact.
    bus.txact = 1'b1; bus.txpop = 1'b1;
    repeat (3) @(negedge clk);
    bus.txact = 1'b0; bus.txpop = 1'b0;
    b = 8'($urandom);
    send_serial(b, 1'b1);
    rq.push_back(b);
    repeat (2) @(negedge clk);
    check_val("after_empty_txdat", 32'(bus.txdat), 32'(b));
    check_val("after_empty_len", 32'(bus.txdat_len), 1);

    // OUT fill while the serializer is busy; foreign endpoint never ready.
    bus.rxact = 1'b1; bus.endpt = 4'd3; bus.rxdat = 8'hEE; bus.rxval = 1'b1;
    @(negedge clk);
    check_val("ep3_rxrdy", 32'(bus.rxrdy), 0);
    @(negedge clk);
    bus.rxval = 1'b0; bus.endpt = 4'd2;
    @(negedge clk);
    base = mon_byte.size();
    tq = {};
    b = 8'($urandom);
    check_val("stall_rxrdy0", 32'(bus.rxrdy), 1);
    bus.rxdat = b; bus.rxval = 1'b1; tq.push_back(b);
    @(negedge clk);
    bus.rxval = 1'b0;
    repeat (6) @(negedge clk);
    level = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      check_val("fill_rxrdy", 32'(bus.rxrdy), 32'(level < DEPTH));
      bus.rxdat = b; bus.rxval = 1'b1;
      @(negedge clk);
      if (level < DEPTH) begin
        tq.push_back(b);
        level++;
      end
    end
    bus.rxval = 1'b0; bus.rxact = 1'b0;
    wait_mon(base + 9, 9 * FRAME + 400);
    for (int i = 0; i < 9; i++)
      check_val("fill_tx_byte", 32'(mon_byte[base+i]), 32'(tq[i]));

    // Reset in the middle of both a TX and an RX frame.
    check_val("pre_rst_txval", 32'(bus.txval), 1);
    bus.rxact = 1'b1; bus.endpt = 4'd2; bus.rxdat = 8'hC3; bus.rxval = 1'b1;
    fork
      send_serial(8'hF0, 1'b1);
    join_none
    @(negedge clk);
    bus.rxval = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    o0 = ovf_cnt; f0 = frm_cnt;
    @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    rq = {};
    base = mon_byte.size();
    bus.rxact = 1'b0;
    repeat (250) @(negedge clk);
    check_val("post_rst_txval", 32'(bus.txval), 0);
    check_val("post_rst_cork", 32'(bus.txcork), 1);
    check_val("post_rst_len", 32'(bus.txdat_len), 0);
    check_val("post_rst_frames", 32'(mon_byte.size()), 32'(base));
    check_val("post_rst_err", 32'(ovf_cnt - o0 + frm_cnt - f0), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
